// File: rtl/int_rf_pkg.sv
// Shared widths and writeback request record for the
// integer register-file writeback arbiter.
package int_rf_pkg;

  localparam int XLEN         = 32;
  localparam int AW           = 5;
  localparam int NUM_INT_REGS = 32;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/int_rf_wb_arbiter_if.sv
// Writeback request bus, register-file write port
// and forwarding taps of the writeback arbiter.
interface int_rf_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32,
  parameter int AW      = 5
);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*AW-1:0]   req_addr;
  logic [NUM_REQ*XLEN-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;

  logic                    rf_wr_en;
  logic [AW-1:0]           rf_wr_addr;
  logic [XLEN-1:0]         rf_wr_data;

  logic [AW-1:0]           rd_addr1;
  logic [AW-1:0]           rd_addr2;
  logic                    fwd_hit1;
  logic                    fwd_hit2;
  logic [XLEN-1:0]         fwd_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready,
    input  rf_wr_en,
    input  rf_wr_addr,
    input  rf_wr_data,
    output rd_addr1,
    output rd_addr2,
    input  fwd_hit1,
    input  fwd_hit2,
    input  fwd_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready,
    output rf_wr_en,
    output rf_wr_addr,
    output rf_wr_data,
    input  rd_addr1,
    input  rd_addr2,
    output fwd_hit1,
    output fwd_hit2,
    output fwd_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the
// scan at the pointer, pointer moves past the winner.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         adv_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] off;
  logic [PW-1:0] gidx;
  logic [PW:0]   sum;
  logic [N-1:0]  rot;
  logic          found;

  // Rotate so the pointer slot sits at bit 0, then
  // take the lowest set bit as the offset.
  always_comb begin
    rot   = N'({req_i, req_i} >> ptr_q);
    found = 1'b0;
    off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = PW'(k);
      end
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= (PW+1)'(N)) begin
      sum = sum - (PW+1)'(N);
    end
    gidx  = sum[PW-1:0];
    gnt_o = '0;
    if (found && !rst) begin
      gnt_o[gidx] = 1'b1;
    end
    ptr_d = ptr_q;
    if (adv_i && found) begin
      if (gidx == PW'(N - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gidx + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/int_rf_wb_arbiter.sv
// Shares the integer register-file write port among
// writeback sources; stages one write per cycle.
module int_rf_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = int_rf_pkg::XLEN,
  parameter int AW      = int_rf_pkg::AW
) (
  input  logic                clk,
  input  logic                rst,
  int_rf_wb_arbiter_if.slave  bus
);

  import int_rf_pkg::*;

  logic [NUM_REQ-1:0] gnt;
  logic               xfer;
  logic [AW-1:0]      sel_addr;
  logic [XLEN-1:0]    sel_data;

  logic               wr_en_q;
  logic               wr_en_d;
  logic [AW-1:0]      wr_addr_q;
  logic [AW-1:0]      wr_addr_d;
  logic [XLEN-1:0]    wr_data_q;
  logic [XLEN-1:0]    wr_data_d;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .clk   (clk),
    .rst   (rst),
    .req_i (bus.req_valid),
    .adv_i (xfer),
    .gnt_o (gnt)
  );

  assign xfer          = |gnt;
  assign bus.req_ready = gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = bus.req_addr[i*AW +: AW];
        sel_data = bus.req_data[i*XLEN +: XLEN];
      end
    end
  end

  // x0 writes are consumed but never reach the file.
  always_comb begin
    wr_en_d   = xfer && (sel_addr != '0);
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (xfer) begin
      wr_addr_d = sel_addr;
      wr_data_d = sel_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.rf_wr_en   = wr_en_q;
  assign bus.rf_wr_addr = wr_addr_q;
  assign bus.rf_wr_data = wr_data_q;

  assign bus.fwd_hit1 = wr_en_q &&
                        (bus.rd_addr1 == wr_addr_q);
  assign bus.fwd_hit2 = wr_en_q &&
                        (bus.rd_addr2 == wr_addr_q);
  assign bus.fwd_data = wr_data_q;

endmodule

// File: tb/tb_int_rf_wb_arbiter.sv
// Bench for int_rf_wb_arbiter: spec-level model plus
// directed writeback scenarios and literal checks.
module tb_int_rf_wb_arbiter;

  import int_rf_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int_rf_wb_arbiter_if #(
    .NUM_REQ (N),
    .XLEN    (XLEN),
    .AW      (AW)
  ) bus ();

  int_rf_wb_arbiter #(
    .NUM_REQ (N),
    .XLEN    (XLEN),
    .AW      (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wb_req_t req [N];

  always_comb begin
    bus.req_addr = '0;
    bus.req_data = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW]     = req[i].addr;
      bus.req_data[i*XLEN +: XLEN] = req[i].data;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  // Register file seen by the write port (x0 not
  // special-cased here so a leaked x0 write shows).
  logic [31:0] rf_mem [32] = '{default: 32'h0};
  always @(posedge clk) begin
    if (bus.rf_wr_en) begin
      rf_mem[bus.rf_wr_addr] <= bus.rf_wr_data;
    end
  end

  // Model: first valid index at or after the pointer.
  function automatic int grant_idx(int p,
                                   logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  int          m_ptr;
  int          m_gi;
  logic        m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [N-1:0] exp_ready;

  always_comb begin
    m_gi      = grant_idx(m_ptr, bus.req_valid);
    exp_ready = '0;
    if (!rst && m_gi >= 0) exp_ready[m_gi] = 1'b1;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_en   <= 1'b0;
      m_addr <= '0;
      m_data <= '0;
      m_ptr  <= 0;
    end else if (m_gi >= 0) begin
      m_en   <= (req[m_gi].addr != 5'd0);
      m_addr <= req[m_gi].addr;
      m_data <= req[m_gi].data;
      m_ptr  <= (m_gi + 1) % N;
    end else begin
      m_en <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("ready", 32'(bus.req_ready), 32'(exp_ready));
    chk("wr_en", 32'(bus.rf_wr_en), 32'(m_en));
    chk("hit1", 32'(bus.fwd_hit1),
        32'(m_en && bus.rd_addr1 == m_addr));
    chk("hit2", 32'(bus.fwd_hit2),
        32'(m_en && bus.rd_addr2 == m_addr));
    if (m_en) begin
      chk("wr_addr", 32'(bus.rf_wr_addr), 32'(m_addr));
      chk("wr_data", bus.rf_wr_data, m_data);
      chk("fwd_data", bus.fwd_data, m_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] exp_g [6];
  logic [4:0]   exp_a [6];

  initial begin
    exp_g = '{3'b010, 3'b100, 3'b001,
              3'b010, 3'b100, 3'b001};
    exp_a = '{5'd2, 5'd3, 5'd1, 5'd2, 5'd3, 5'd1};
    bus.req_valid = '0;
    bus.rd_addr1  = '0;
    bus.rd_addr2  = '0;
    for (int i = 0; i < N; i++) req[i] = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    repeat (3) begin
      @(negedge clk);
      chk("idle_ready", 32'(bus.req_ready), 32'h0);
      chk("idle_en", 32'(bus.rf_wr_en), 32'h0);
    end

    tick();
    req[0] = '{addr: 5'd5, data: 32'hDEADBEEF};
    bus.req_valid = 3'b001;
    @(negedge clk);
    chk("single_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    chk("single_en", 32'(bus.rf_wr_en), 32'h1);
    chk("single_addr", 32'(bus.rf_wr_addr), 32'h5);
    chk("single_data", bus.rf_wr_data, 32'hDEADBEEF);
    tick();
    chk("single_rf", rf_mem[5], 32'hDEADBEEF);

    req[0] = '{addr: 5'd1, data: 32'h11};
    req[1] = '{addr: 5'd2, data: 32'h22};
    req[2] = '{addr: 5'd3, data: 32'h33};
    bus.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_grant", 32'(bus.req_ready), 32'(exp_g[k]));
      if (k > 0) begin
        chk("rr_en", 32'(bus.rf_wr_en), 32'h1);
        chk("rr_addr", 32'(bus.rf_wr_addr),
            32'(exp_a[k-1]));
      end
      tick();
    end
    bus.req_valid = '0;
    @(negedge clk);
    chk("rr_last", 32'(bus.rf_wr_addr), 32'h1);
    tick();

    req[1] = '{addr: 5'd0, data: 32'hFFFFFFFF};
    bus.req_valid = 3'b010;
    bus.rd_addr1  = 5'd0;
    @(negedge clk);
    chk("x0_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    chk("x0_en", 32'(bus.rf_wr_en), 32'h0);
    chk("x0_hit1", 32'(bus.fwd_hit1), 32'h0);
    tick();
    chk("x0_rf", rf_mem[0], 32'h0);

    req[2] = '{addr: 5'd7, data: 32'h1234};
    bus.req_valid = 3'b100;
    @(negedge clk);
    chk("fwd_ready", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = '0;
    bus.rd_addr1  = 5'd7;
    bus.rd_addr2  = 5'd8;
    @(negedge clk);
    chk("fwd_hit1", 32'(bus.fwd_hit1), 32'h1);
    chk("fwd_hit2", 32'(bus.fwd_hit2), 32'h0);
    chk("fwd_val", bus.fwd_data, 32'h1234);
    tick();

    req[0] = '{addr: 5'd9, data: 32'hA};
    req[1] = '{addr: 5'd9, data: 32'hB};
    bus.req_valid = 3'b011;
    @(negedge clk);
    chk("dup_g0", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 3'b010;
    @(negedge clk);
    chk("dup_g1", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    tick();
    chk("dup_rf", rf_mem[9], 32'hB);

    req[1] = '{addr: 5'd12, data: 32'hCAFE};
    bus.req_valid = 3'b010;
    @(negedge clk);
    chk("rst_pre_g", 32'(bus.req_ready), 32'h2);
    tick();
    req[1] = '{addr: 5'd14, data: 32'h14};
    req[2] = '{addr: 5'd13, data: 32'h13};
    bus.req_valid = 3'b110;
    #1;
    chk("rst_pre_en", 32'(bus.rf_wr_en), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_async_en", 32'(bus.rf_wr_en), 32'h0);
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_post_g", 32'(bus.req_ready), 32'h2);
    chk("rst_rf", rf_mem[12], 32'h0);
    tick();
    bus.req_valid = '0;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
